vga_fb_ctrl: RTL and testbench

//  Parametrised VGA timing generator with indexed-colour framebuffer and programmable palette.

---
 rtl/vga_fb_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_vga_fb_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_ctrl.sv
// -----------------------------------------------------------------------------
// vga_fb_ctrl
//   VGA timing generator with an indexed-colour framebuffer and a programmable
//   palette. Free-running h/v counters scan the framebuffer during the active
//   area. Each index is mapped through the palette to 12-bit RGB. The host
//   writes pixels by (x,y) and palette entries at any time.
//
//   Optional feature macro: VGA_FB_DOUBLE_BUFFER_EN
//     defined   : two framebuffer banks. The scan reads the front bank and host
//                 writes go to the back bank. A swap request is held pending
//                 and takes effect on the last cycle of a frame.
//     undefined : one bank shared by scan and host. swap_req is ignored and
//                 swap_ack is tied low.
//
// Ports
//   clk, arstn          pixel clock, asynchronous active-low reset
//   wr_en/wr_x/wr_y     framebuffer write of wr_idx at (wr_x,wr_y);
//   wr_idx              out-of-range coordinates are dropped
//   pal_we/pal_addr/    palette write, colour {B[11:8],G[7:4],R[3:0]}
//   pal_data
//   swap_req, swap_ack  bank swap request / one-cycle acknowledge
//   VGA_HS, VGA_VS      sync outputs, level HS_POL/VS_POL during retrace
//   RGB                 pixel colour, 0 outside the active area
//   vblank              high while the line is outside the active lines
//   frame_start         one-cycle pulse on the first active pixel of a frame
//   RGB, syncs, vblank and frame_start all lag the counters by 3 cycles.
// -----------------------------------------------------------------------------
module vga_fb_ctrl #(
    parameter int   HD       = 1280,
    parameter int   HF       = 48,
    parameter int   HR       = 112,
    parameter int   HB       = 248,
    parameter int   VD       = 1024,
    parameter int   VF       = 1,
    parameter int   VR       = 3,
    parameter int   VB       = 38,
    parameter int   HBITS    = 11,
    parameter int   VBITS    = 11,
    parameter int   PIX_BITS = 2,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic                clk,
    input  logic                arstn,
    input  logic                wr_en,
    input  logic [HBITS-1:0]    wr_x,
    input  logic [VBITS-1:0]    wr_y,
    input  logic [PIX_BITS-1:0] wr_idx,
    input  logic                pal_we,
    input  logic [PIX_BITS-1:0] pal_addr,
    input  logic [11:0]         pal_data,
    input  logic                swap_req,
    output logic                swap_ack,
    output logic                VGA_HS,
    output logic                VGA_VS,
    output logic [11:0]         RGB,
    output logic                vblank,
    output logic                frame_start
);
    localparam int HMAX   = HD + HF + HR + HB - 1;
    localparam int VMAX   = VD + VF + VR + VB - 1;
    localparam int HSTART = HR + HB;
    localparam int VSTART = VR + VB;
    localparam int DEPTH  = HD * VD;
    localparam int ABITS  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NPAL   = 2 ** PIX_BITS;

    function automatic logic [11:0] pal_default(input int i);
        case (i)
            0:       return 12'h000;
            1:       return 12'hFFF;
            2:       return 12'hF00;
            3:       return 12'h0F0;
            default: return 12'h000;
        endcase
    endfunction

    // ---------------- stage 0: counters ----------------
    logic [HBITS-1:0] hcount;
    logic [VBITS-1:0] vcount;
    logic             line_end, frame_end, h_act, v_act;
    logic [HBITS-1:0] px;
    logic [VBITS-1:0] py;
    logic [ABITS-1:0] scan_addr, wr_addr;
    logic             wr_ok;

    // NOTE: every always_comb output gets a value on every path, so no latches.
    always_comb begin
        line_end  = (hcount == HBITS'(HMAX));
        frame_end = line_end && (vcount == VBITS'(VMAX));
        h_act     = (hcount >= HBITS'(HSTART)) && (hcount < HBITS'(HSTART + HD));
        v_act     = (vcount >= VBITS'(VSTART)) && (vcount < VBITS'(VSTART + VD));
        px        = hcount - HBITS'(HSTART);
        py        = vcount - VBITS'(VSTART);
        scan_addr = ABITS'(py) * ABITS'(HD) + ABITS'(px);
        wr_ok     = wr_en && (wr_x < HBITS'(HD)) && (wr_y < VBITS'(VD));
        wr_addr   = ABITS'(wr_y) * ABITS'(HD) + ABITS'(wr_x);
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            hcount <= '0;
            vcount <= '0;
        end else if (line_end) begin
            hcount <= '0;
            vcount <= (vcount == VBITS'(VMAX)) ? '0 : vcount + VBITS'(1);
        end else begin
            hcount <= hcount + HBITS'(1);
        end
    end

    // ---------------- palette ----------------
    logic [11:0] pal [NPAL];

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            for (int i = 0; i < NPAL; i++) pal[i] <= pal_default(i);
        end else if (pal_we) begin
            pal[pal_addr] <= pal_data;
        end
    end

    // ---------------- bank control ----------------
    logic                rd_bank;
`ifdef VGA_FB_DOUBLE_BUFFER_EN
    logic front, pending;

    // A request arriving on the boundary cycle swaps immediately; otherwise it
    // waits as pending. Requests while pending collapse into one swap.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            front    <= 1'b0;
            pending  <= 1'b0;
            swap_ack <= 1'b0;
            rd_bank  <= 1'b0;
        end else begin
            rd_bank  <= front;
            swap_ack <= 1'b0;
            if (frame_end && (pending || swap_req)) begin
                front    <= ~front;
                pending  <= 1'b0;
                swap_ack <= 1'b1;
            end else if (swap_req) begin
                pending <= 1'b1;
            end
        end
    end
`else
    logic unused_swap;
    assign unused_swap = swap_req ^ frame_end;
    assign swap_ack    = 1'b0;
    assign rd_bank     = 1'b0;
`endif

    // ---------------- framebuffer ----------------
    logic [ABITS-1:0]    rd_addr;
    logic [PIX_BITS-1:0] idx2;

    // NOTE: the framebuffer has no reset so it can map onto block RAM; write
    // and read sit in one non-blocking process, so a same-address read sees
    // the old data.
`ifdef VGA_FB_DOUBLE_BUFFER_EN
    logic [PIX_BITS-1:0] fb [2][DEPTH];

    always_ff @(posedge clk) begin
        if (wr_ok) fb[~front][wr_addr] <= wr_idx;
        idx2 <= fb[rd_bank][rd_addr];
    end
`else
    logic [PIX_BITS-1:0] fb [DEPTH];
    logic                unused_bank;
    assign unused_bank = rd_bank;

    always_ff @(posedge clk) begin
        if (wr_ok) fb[wr_addr] <= wr_idx;
        idx2 <= fb[rd_addr];
    end
`endif

    // ---------------- stages 1..3 ----------------
    logic de1, hs1, vs1, vb1, fs1;
    logic de2, hs2, vs2, vb2, fs2;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rd_addr     <= '0;
            {de1, fs1}  <= '0;
            {de2, fs2}  <= '0;
            hs1         <= ~HS_POL;
            hs2         <= ~HS_POL;
            vs1         <= ~VS_POL;
            vs2         <= ~VS_POL;
            vb1         <= 1'b1;
            vb2         <= 1'b1;
            RGB         <= '0;
            VGA_HS      <= ~HS_POL;
            VGA_VS      <= ~VS_POL;
            vblank      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            // stage 1: scan address and timing flags
            rd_addr <= scan_addr;
            de1     <= h_act && v_act;
            hs1     <= (hcount < HBITS'(HR)) ? HS_POL : ~HS_POL;
            vs1     <= (vcount < VBITS'(VR)) ? VS_POL : ~VS_POL;
            vb1     <= ~v_act;
            fs1     <= (hcount == HBITS'(HSTART)) && (vcount == VBITS'(VSTART));
            // stage 2: flags ride alongside the framebuffer read
            {de2, hs2, vs2, vb2, fs2} <= {de1, hs1, vs1, vb1, fs1};
            // stage 3: palette lookup
            RGB         <= de2 ? pal[idx2] : 12'h000;
            VGA_HS      <= hs2;
            VGA_VS      <= vs2;
            vblank      <= vb2;
            frame_start <= fs2;
        end
    end
endmodule

// File: tb/tb_vga_fb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_fb_ctrl
//   Scoreboard bench for vga_fb_ctrl with small timing (14 x 7 per frame).
//   The driver advances a behavioural model one pixel per cycle and queues the
//   expected output for every counter position. The monitor pops one entry per
//   cycle and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_vga_fb_ctrl;
    localparam int HD = 8, HF = 2, HR = 2, HB = 2;
    localparam int VD = 4, VF = 1, VR = 1, VB = 1;
    localparam int HBITS = 4, VBITS = 3, PIX_BITS = 2;
    localparam int HTOT = HD + HF + HR + HB;   // 14
    localparam int VTOT = VD + VF + VR + VB;   // 7
    localparam int FRAME = HTOT * VTOT;        // 98

    logic                clk = 1'b0;
    logic                arstn = 1'b0;
    logic                wr_en = 1'b0;
    logic [HBITS-1:0]    wr_x = '0;
    logic [VBITS-1:0]    wr_y = '0;
    logic [PIX_BITS-1:0] wr_idx = '0;
    logic                pal_we = 1'b0;
    logic [PIX_BITS-1:0] pal_addr = '0;
    logic [11:0]         pal_data = '0;
    logic                swap_req = 1'b0;
    logic                swap_ack, VGA_HS, VGA_VS, vblank, frame_start;
    logic [11:0]         RGB;

    vga_fb_ctrl #(
        .HD(HD), .HF(HF), .HR(HR), .HB(HB),
        .VD(VD), .VF(VF), .VR(VR), .VB(VB),
        .HBITS(HBITS), .VBITS(VBITS), .PIX_BITS(PIX_BITS),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk(clk), .arstn(arstn),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_idx(wr_idx),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .swap_req(swap_req), .swap_ack(swap_ack),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .RGB(RGB),
        .vblank(vblank), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] rgb;
        bit          known;
        bit          hs, vs, vb, fs;
        int          h, v;
    } exp_t;

    typedef struct {
        bit          we;
        int          x, y, idx;
        bit          pwe;
        int          paddr;
        logic [11:0] pdata;
        bit          swap;
    } stim_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_on = 1'b0;

    // behavioural model state
    int          fb_m [2][HD*VD];   // -1 = never written
    logic [11:0] pal_m [4];
    int          mh, mv;
    bit          front_m, pend_m, prev_req;
    bit          have_pend, p_act;
    int          p_idx;
    exp_t        p_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic bit is_active(input int h, input int v);
        return (h >= HR + HB) && (h < HR + HB + HD) && (v >= VR + VB) && (v < VR + VB + VD);
    endfunction

    function automatic exp_t state_exp(input int h, input int v);
        exp_t e;
        e.rgb   = 12'h000;
        e.known = 1'b1;
        e.hs    = (h < HR);
        e.vs    = (v < VR);
        e.vb    = !((v >= VR + VB) && (v < VR + VB + VD));
        e.fs    = (h == HR + HB) && (v == VR + VB);
        e.h     = h;
        e.v     = v;
        return e;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e.rgb = 12'h000; e.known = 1'b1;
        e.hs = 1'b0; e.vs = 1'b0; e.vb = 1'b1; e.fs = 1'b0;
        e.h = -1; e.v = -1;
        return e;
    endfunction

    function automatic stim_t idle_s();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic stim_t wr_s(input int x, input int y, input int idx);
        stim_t s;
        s = idle_s();
        s.we = 1'b1; s.x = x; s.y = y; s.idx = idx;
        return s;
    endfunction

    function automatic stim_t rand_s();
        stim_t s;
        s = idle_s();
        s.we    = ($urandom_range(0, 1) == 1);
        s.x     = $urandom_range(0, 9);
        s.y     = $urandom_range(0, 4);
        s.idx   = $urandom_range(0, 3);
        s.pwe   = ($urandom_range(0, 19) == 0);
        s.paddr = $urandom_range(0, 3);
        s.pdata = 12'($urandom);
        s.swap  = ($urandom_range(0, 59) == 0);
        return s;
    endfunction

    // Apply one cycle's stimulus to the DUT and to the model.
    task automatic drive(input stim_t s);
        int bank;
        wr_en    = s.we;
        wr_x     = s.x[HBITS-1:0];
        wr_y     = s.y[VBITS-1:0];
        wr_idx   = s.idx[PIX_BITS-1:0];
        pal_we   = s.pwe;
        pal_addr = s.paddr[PIX_BITS-1:0];
        pal_data = s.pdata;
        swap_req = s.swap;
`ifdef VGA_FB_DOUBLE_BUFFER_EN
        bank = front_m ? 0 : 1;
        prev_req = s.swap;
`else
        bank = 0;
`endif
        if (s.we && s.x < HD && s.y < VD) fb_m[bank][s.y * HD + s.x] = s.idx;
        if (s.pwe) pal_m[s.paddr] = s.pdata;
    endtask

    // The index for the current pixel is fixed now; its colour is fixed one
    // cycle later, once any palette write for that cycle has been applied.
    task automatic resolve_and_capture();
        int bank;
        if (have_pend) begin
            if (p_act) begin
                if (p_idx < 0) p_e.known = 1'b0;
                else           p_e.rgb = pal_m[p_idx];
            end
            sb.push_back(p_e);
        end
`ifdef VGA_FB_DOUBLE_BUFFER_EN
        bank = front_m ? 1 : 0;
`else
        bank = 0;
`endif
        p_e   = state_exp(mh, mv);
        p_act = is_active(mh, mv);
        p_idx = p_act ? fb_m[bank][(mv - VR - VB) * HD + (mh - HR - HB)] : 0;
        have_pend = 1'b1;
    endtask

    task automatic tick(input stim_t s);
        bit do_swap;
        @(negedge clk);
        do_swap = 1'b0;
`ifdef VGA_FB_DOUBLE_BUFFER_EN
        if (mh == HTOT - 1 && mv == VTOT - 1 && (pend_m || prev_req)) begin
            do_swap = 1'b1;
            front_m = !front_m;
            pend_m  = 1'b0;
        end else if (prev_req) begin
            pend_m = 1'b1;
        end
`endif
        check($sformatf("swap_ack h=%0d v=%0d", mh, mv), {31'b0, swap_ack}, {31'b0, do_swap});
        if (mh == HTOT - 1) begin
            mh = 0;
            mv = (mv == VTOT - 1) ? 0 : mv + 1;
        end else begin
            mh++;
        end
        drive(s);
        resolve_and_capture();
    endtask

    task automatic hold_reset(input int n);
        repeat (n) begin
            @(negedge clk);
            arstn = 1'b0;
            drive(idle_s());
            sb.delete();
            sb.push_back(reset_exp());
            have_pend = 1'b0;
            #1 check("swap_ack_in_reset", {31'b0, swap_ack}, 32'd0);
        end
    endtask

    task automatic release_reset(input stim_t s);
        @(negedge clk);
        arstn   = 1'b1;
        mh      = 0;
        mv      = 0;
        front_m = 1'b0;
        pend_m  = 1'b0;
        prev_req = 1'b0;
        have_pend = 1'b0;
        pal_m   = '{12'h000, 12'hFFF, 12'hF00, 12'h0F0};
        sb.delete();
        repeat (3) sb.push_back(reset_exp());
        drive(s);
        resolve_and_capture();
    endtask

    // Fill all 32 pixels; first write may be issued by the caller.
    task automatic fill(input int start, input int idx_all, input bit corners);
        for (int i = start; i < HD * VD; i++) begin
            int v;
            v = idx_all;
            if (corners && i == 0) v = 1;
            if (corners && i == HD * VD - 1) v = 2;
            tick(wr_s(i % HD, i / HD, v));
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) tick(idle_s());
    endtask

    // monitor: one expected entry per cycle
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_on) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL scoreboard_empty: got no expected entry, required one");
                end else begin
                    mon_e = sb.pop_front();
                    check($sformatf("hs h=%0d v=%0d", mon_e.h, mon_e.v), {31'b0, VGA_HS}, {31'b0, mon_e.hs});
                    check($sformatf("vs h=%0d v=%0d", mon_e.h, mon_e.v), {31'b0, VGA_VS}, {31'b0, mon_e.vs});
                    check($sformatf("vblank h=%0d v=%0d", mon_e.h, mon_e.v), {31'b0, vblank}, {31'b0, mon_e.vb});
                    check($sformatf("frame_start h=%0d v=%0d", mon_e.h, mon_e.v),
                          {31'b0, frame_start}, {31'b0, mon_e.fs});
                    if (mon_e.known)
                        check($sformatf("rgb h=%0d v=%0d", mon_e.h, mon_e.v), {20'b0, RGB}, {20'b0, mon_e.rgb});
                end
            end
        end
    end

    initial begin
        int guard;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < HD * VD; i++) fb_m[b][i] = -1;
        mon_on = 1'b1;
        hold_reset(3);

        // frames 1-2: corners pattern, everything else index 0
        release_reset(wr_s(0, 0, 1));
        fill(1, 0, 1'b1);
        idle_cycles(2 * FRAME - HD * VD);

        // palette entry 3 reprogrammed, pixel (4,2) set to index 3
        begin
            stim_t s;
            s = wr_s(4, 2, 3);
            s.pwe = 1'b1; s.paddr = 3; s.pdata = 12'h0A5;
            tick(s);
        end
        idle_cycles(2 * FRAME);

        // out-of-range writes must not land anywhere
        tick(wr_s(8, 0, 3));
        tick(wr_s(0, 4, 3));
        tick(wr_s(15, 7, 3));
        idle_cycles(FRAME);

        // back bank all index 1, then two swap requests in one frame
        fill(0, 1, 1'b0);
        begin
            stim_t s;
            s = idle_s(); s.swap = 1'b1;
            tick(s);
            idle_cycles(10);
            tick(s);
        end
        idle_cycles(2 * FRAME + 20);

        // randomised traffic
        repeat (6 * FRAME) tick(rand_s());

        // reset in the middle of line 2
        guard = 0;
        while (!(mv == 2 && mh == 5) && guard < 2 * FRAME) begin
            tick(rand_s());
            guard++;
        end
        check("reach_line2_in_budget", guard, (guard < 2 * FRAME) ? guard : -1);
        hold_reset(3);
        release_reset(idle_s());
        repeat (2 * FRAME) tick(rand_s());

        mon_on = 1'b0;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
